// File: rtl/mpu6050_burst_reader.sv
// mpu6050_burst_reader: periodically reads the six MPU6050 accel registers one byte per I2C transaction
// and publishes three signed 16-bit samples, aborting any transaction that hangs.
module mpu6050_burst_reader #(
  parameter logic [6:0]  SLAVE_ADDR    = 7'h68,
  parameter logic [7:0]  BASE_REG      = 8'h3B,
  parameter int unsigned SAMPLE_PERIOD = 2500000,
  parameter int unsigned TIMEOUT       = 200000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               i2c_idle_i,
  input  logic               i2c_data_valid_i,
  input  logic [7:0]         i2c_data_i,
  output logic               i2c_start_o,
  output logic               i2c_stop_o,
  output logic [6:0]         i2c_slave_address_o,
  output logic [7:0]         i2c_reg_addr_o,
  output logic signed [15:0] accel_x_o,
  output logic signed [15:0] accel_y_o,
  output logic signed [15:0] accel_z_o,
  output logic               sample_valid_o,
  output logic               busy_o,
  output logic               timeout_err_o,
  output logic [7:0]         err_count_o
);
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, ISSUE, WAIT_DATA, STOP_REQ, WAIT_IDLE, NEXT, PUBLISH, ABORT, DRAIN
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [WW-1:0] wait_q;
  logic [2:0]    idx_q;
  logic [7:0]    bytes_q [6];
  logic [15:0]   ax_q, ay_q, az_q;
  logic [7:0]    err_q;
  logic          pending_q, pending_d, dv_q, start_q, stop_q, valid_q, terr_q;
  logic          tick_hit, dv_rise, timed_out, launch, waiting, abort;

  assign tick_hit  = tick_q == TW'(SAMPLE_PERIOD - 1);
  assign dv_rise   = i2c_data_valid_i & ~dv_q;
  assign timed_out = wait_q == WW'(TIMEOUT - 1);
  // A tick in the same cycle counts as pending so IDLE launches on the very next edge.
  assign launch    = (state_q == IDLE) & (pending_q | tick_hit) & enable_i & i2c_idle_i;
  assign pending_d = ~launch & (pending_q | tick_hit);
  assign waiting   = (state_q == ISSUE) | (state_q == WAIT_DATA) | (state_q == WAIT_IDLE);
  assign abort     = timed_out & (((state_q == ISSUE) & i2c_idle_i) |
                                  ((state_q == WAIT_DATA) & ~dv_rise) |
                                  ((state_q == WAIT_IDLE) & ~i2c_idle_i));

  assign i2c_start_o         = start_q;
  assign i2c_stop_o          = stop_q;
  assign i2c_slave_address_o = SLAVE_ADDR;
  assign i2c_reg_addr_o      = BASE_REG + {5'd0, idx_q};
  assign accel_x_o           = ax_q;
  assign accel_y_o           = ay_q;
  assign accel_z_o           = az_q;
  assign sample_valid_o      = valid_q;
  assign busy_o              = state_q != IDLE;
  assign timeout_err_o       = terr_q;
  assign err_count_o         = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      wait_q    <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      dv_q      <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
      err_q     <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      az_q      <= '0;
      for (int i = 0; i < 6; i++) bytes_q[i] <= '0;
    end else begin
      tick_q    <= tick_hit ? '0 : tick_q + TW'(1);
      pending_q <= pending_d;
      dv_q      <= i2c_data_valid_i;
      wait_q    <= waiting ? wait_q + WW'(1) : '0;
      stop_q    <= 1'b0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
      if (abort) begin
        state_q <= ABORT;
        start_q <= 1'b0;
        stop_q  <= 1'b1;
        terr_q  <= 1'b1;
        err_q   <= (err_q != 8'hFF) ? err_q + 8'd1 : err_q;
      end else begin
        case (state_q)
          IDLE: if (launch) begin
            state_q <= ISSUE;
            idx_q   <= '0;
            start_q <= 1'b1;
          end
          ISSUE: if (!i2c_idle_i) begin
            state_q <= WAIT_DATA;
            start_q <= 1'b0;
            wait_q  <= '0;
          end
          WAIT_DATA: if (dv_rise) begin
            bytes_q[idx_q] <= i2c_data_i;
            state_q        <= STOP_REQ;
            stop_q         <= 1'b1;
          end
          STOP_REQ:  state_q <= WAIT_IDLE;
          WAIT_IDLE: if (i2c_idle_i) state_q <= NEXT;
          NEXT: if (idx_q == 3'd5) begin
            state_q <= PUBLISH;
            ax_q    <= {bytes_q[0], bytes_q[1]};
            ay_q    <= {bytes_q[2], bytes_q[3]};
            az_q    <= {bytes_q[4], bytes_q[5]};
            valid_q <= 1'b1;
          end else begin
            state_q <= ISSUE;
            idx_q   <= idx_q + 3'd1;
            start_q <= 1'b1;
          end
          PUBLISH: state_q <= IDLE;
          ABORT:   state_q <= DRAIN;
          DRAIN:   if (i2c_idle_i) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mpu6050_burst_reader.sv
// tb_mpu6050_burst_reader: directed frames against a bus-functional I2C master, with a sample scoreboard.
module tb_mpu6050_burst_reader;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic        i2c_idle = 1'b1, dv = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        start, stop, sv, busy, terr;
  logic [6:0]  slave;
  logic [7:0]  reg_addr, err;
  logic [15:0] ax, ay, az;

  mpu6050_burst_reader #(.SAMPLE_PERIOD(50), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .i2c_idle_i(i2c_idle),
    .i2c_data_valid_i(dv), .i2c_data_i(data), .i2c_start_o(start), .i2c_stop_o(stop),
    .i2c_slave_address_o(slave), .i2c_reg_addr_o(reg_addr), .accel_x_o(ax), .accel_y_o(ay),
    .accel_z_o(az), .sample_valid_o(sv), .busy_o(busy), .timeout_err_o(terr), .err_count_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] x, y, z;} smp_t;
  smp_t exp_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] resp [36] = '{
    8'h12, 8'h34, 8'hFF, 8'h80, 8'h00, 8'h01,
    8'h7F, 8'hFF, 8'h80, 8'h00, 8'hAA, 8'h55,
    8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h02,
    8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11,
    8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'h0F, 8'hF0,
    8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};

  int vectors = 0, miscompares = 0;
  int cyc = 0, n_start = 0, n_stop = 0, n_fall = 0, n_sv = 0, n_to = 0, both = 0;
  int rise_cyc = 0, fall_cyc = 0, sv_cyc = 0, to_cyc = 0, snap_start = 0, snap_stop = 0;
  logic start_prev = 1'b0, to_stop = 1'b0;
  int hang_byte = 7, fidx = -1;
  bit never_accept = 0, ext_busy = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endfunction

  function automatic int get(int w);
    return w == 0 ? n_start : w == 1 ? n_sv : w == 2 ? n_to : n_fall;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_for(input string name, input int w, input int target, input int budget);
    int n = 0;
    while (get(w) < target && n < budget) begin
      step();
      n++;
    end
    check(name, get(w), target);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_stop"}, stop, 0);
    check({tag, "_reg_addr"}, reg_addr, 8'h3B);
    check({tag, "_slave"}, slave, 7'h68);
    check({tag, "_ax"}, ax, 0);
    check({tag, "_ay"}, ay, 0);
    check({tag, "_az"}, az, 0);
    check({tag, "_valid"}, sv, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_terr"}, terr, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Bus-functional master: accept after 2 cycles, data after 3, back to idle 2 cycles after stop.
  initial begin : bfm
    int m_st, m_cnt, k;
    m_st = 0; m_cnt = 0; k = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_st = 0; i2c_idle = 1'b1; dv = 1'b0;
      end else if (m_st == 0) begin
        i2c_idle = !ext_busy;
        if (start && !ext_busy && !never_accept) begin m_st = 1; m_cnt = 2; end
      end else if (m_st == 1) begin
        m_cnt--;
        if (m_cnt == 0) begin
          i2c_idle = 1'b0;
          k = int'(reg_addr) - 'h3B;
          if (k == 0) fidx++;
          m_st = 2; m_cnt = 3;
        end
      end else if (m_st == 2) begin
        if (stop) begin m_st = 4; m_cnt = 2; end
        else if (k != hang_byte) begin
          m_cnt--;
          if (m_cnt == 0) begin dv = 1'b1; data = resp[(fidx % 6) * 6 + k]; m_st = 3; end
        end
      end else if (m_st == 3) begin
        if (stop) begin dv = 1'b0; m_st = 4; m_cnt = 2; end
      end else begin
        dv = 1'b0;
        m_cnt--;
        if (m_cnt == 0) begin i2c_idle = 1'b1; m_st = 0; end
      end
    end
  end

  always @(negedge clk) begin : mon
    smp_t e;
    cyc++;
    if (start && !start_prev) begin n_start++; rise_cyc = cyc; addr_q.push_back(reg_addr); end
    if (!start && start_prev) begin n_fall++; fall_cyc = cyc; end
    start_prev = start;
    if (stop) n_stop++;
    if (start && stop) both++;
    if (terr) begin n_to++; to_cyc = cyc; to_stop = stop; end
    if (sv) begin
      n_sv++; sv_cyc = cyc; snap_start = n_start; snap_stop = n_stop;
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("accel_x", ax, e.x);
        check("accel_y", ay, e.y);
        check("accel_z", az, e.z);
      end
    end
  end

  initial begin : main
    int v1, base;
    repeat (3) step();
    check_reset_vals("rst");
    exp_q.push_back('{16'h1234, 16'hFF80, 16'h0001});
    exp_q.push_back('{16'h7FFF, 16'h8000, 16'hAA55});
    exp_q.push_back('{16'h0000, 16'hFFFF, 16'h0102});
    exp_q.push_back('{16'h5AA5, 16'hC33C, 16'h0FF0});
    reset = 1'b0; enable = 1'b1;
    wait_for("frame0_valid", 1, 1, 300);
    v1 = sv_cyc;
    check("frame0_starts", snap_start, 6);
    check("frame0_stops", snap_stop, 6);
    for (int i = 0; i < 6; i++) check("reg_addr_seq", addr_q[i], 8'h3B + 8'(i));
    wait_for("frame1_start", 0, 7, 10);
    check("back_to_back_gap", rise_cyc - v1, 2);
    wait_for("frame1_valid", 1, 2, 200);
    enable = 1'b0;
    ext_busy = 1;
    repeat (100) step();
    enable = 1'b1;
    repeat (200) step();
    check("hold_no_start", n_start, 12);
    ext_busy = 0;
    wait_for("frame2_start", 0, 13, 3);
    wait_for("frame2_byte2", 0, 15, 100);
    enable = 1'b0;
    wait_for("frame2_valid", 1, 3, 200);
    repeat (300) step();
    check("disabled_no_start", n_start, 18);
    hang_byte = 3; enable = 1'b1;
    wait_for("resume_start", 0, 19, 3);
    wait_for("timeout_pulse", 2, 1, 400);
    hang_byte = 7;
    check("timeout_latency", to_cyc - fall_cyc, 100);
    check("abort_stop", to_stop, 1);
    check("abort_stop_count", n_stop, 22);
    check("abort_busy", busy, 1);
    check("err_after_abort", err, 1);
    check("retain_x", ax, 16'h0000);
    check("retain_y", ay, 16'hFFFF);
    check("retain_z", az, 16'h0102);
    wait_for("post_abort_valid", 1, 4, 300);
    hang_byte = 4;
    wait_for("frame5_byte4", 3, 33, 200);
    repeat (5) step();
    reset = 1'b1;
    step();
    check_reset_vals("midrst");
    reset = 1'b0; enable = 1'b0;
    repeat (20) step();
    check("no_valid_after_reset", n_sv, 4);
    never_accept = 1; enable = 1'b1; base = n_to;
    wait_for("issue_timeout", 2, base + 1, 200);
    check("issue_timeout_latency", to_cyc - rise_cyc, 100);
    check("err_first", err, 1);
    wait_for("timeouts_255", 2, base + 255, 30000);
    check("err_255", err, 255);
    wait_for("timeouts_257", 2, base + 257, 400);
    check("err_saturated", err, 255);
    check("start_stop_overlap", both, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
